// File: rtl/instr_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module : seq_pkg
// Brief  : Opcodes, ALU encodings, FSM states and instruction field positions
//          shared by the instruction sequencer.
// Rev    : 1.0 - initial release
// ============================================================================
package seq_pkg;

    localparam logic [3:0] c_opc_add  = 4'h0;
    localparam logic [3:0] c_opc_sub  = 4'h1;
    localparam logic [3:0] c_opc_and  = 4'h2;
    localparam logic [3:0] c_opc_or   = 4'h3;
    localparam logic [3:0] c_opc_not  = 4'h4;
    localparam logic [3:0] c_opc_ldi  = 4'h8;
    localparam logic [3:0] c_opc_jmp  = 4'h9;
    localparam logic [3:0] c_opc_bz   = 4'hA;
    localparam logic [3:0] c_opc_bn   = 4'hB;
    localparam logic [3:0] c_opc_cmp  = 4'hC;
    localparam logic [3:0] c_opc_halt = 4'hF;

    localparam logic [2:0] c_alu_add = 3'b000;
    localparam logic [2:0] c_alu_sub = 3'b001;
    localparam logic [2:0] c_alu_and = 3'b010;
    localparam logic [2:0] c_alu_or  = 3'b011;
    localparam logic [2:0] c_alu_not = 3'b100;

    localparam int c_flg_zero = 1;
    localparam int c_flg_neg  = 0;

    localparam int c_opc_lsb = 12;
    localparam int c_rd_lsb  = 9;
    localparam int c_rs1_lsb = 6;
    localparam int c_rs2_lsb = 3;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_WB     = 3'd3,
        ST_HALT   = 3'd4
    } state_t;

    function automatic logic uses_alu(input logic [3:0] opc);
        return (opc inside {c_opc_add, c_opc_sub, c_opc_and, c_opc_or, c_opc_not, c_opc_cmp});
    endfunction

    // CMP is a SUB whose result is discarded
    function automatic logic [2:0] alu_op_of(input logic [3:0] opc);
        logic [2:0] op;
        op = c_alu_add;
        case (opc)
            c_opc_sub, c_opc_cmp: op = c_alu_sub;
            c_opc_and:            op = c_alu_and;
            c_opc_or:             op = c_alu_or;
            c_opc_not:            op = c_alu_not;
            default:              op = c_alu_add;
        endcase
        return op;
    endfunction

endpackage
`default_nettype wire

// File: rtl/instr_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module : instr_sequencer_if
// Brief  : Instruction fetch handshake and ALU drive/return bundle.
// Rev    : 1.0 - initial release
// ============================================================================
interface instr_sequencer_if #(
    parameter int PC_W = 8
);
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_ack;
    logic [15:0]     imem_data;
    logic            alu_en;
    logic [2:0]      alu_op;
    logic            alu_flgon;
    logic [15:0]     alu_d1;
    logic [15:0]     alu_d2;
    logic [15:0]     alureg;
    logic [1:0]      flg;
    logic            halted;

    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_data,
        output alu_en, alu_op, alu_flgon, alu_d1, alu_d2,
        input  alureg, flg,
        output halted
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_data,
        input  alu_en, alu_op, alu_flgon, alu_d1, alu_d2,
        output alureg, flg,
        input  halted
    );
endinterface
`default_nettype wire

// File: rtl/instr_sequencer_reg_file.sv
`default_nettype none
// ============================================================================
// Module : reg_file
// Brief  : 8x16 register file, two async read ports, one sync write port.
// Rev    : 1.0 - initial release
// ============================================================================
module reg_file #(
    parameter int NREG = 8
) (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        i_we,
    input  wire logic [2:0]  i_waddr,
    input  wire logic [15:0] i_wdata,
    input  wire logic [2:0]  i_raddr1,
    input  wire logic [2:0]  i_raddr2,
    output logic      [15:0] o_rdata1,
    output logic      [15:0] o_rdata2
);
    logic [15:0] r_mem [NREG];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) r_mem[i] <= '0;
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata1 = r_mem[i_raddr1];
    assign o_rdata2 = r_mem[i_raddr2];
endmodule
`default_nettype wire

// File: rtl/instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module : instr_sequencer
// Brief  : Fetch/decode/execute/writeback controller driving a combinational ALU.
// Rev    : 1.0 - initial release
// ============================================================================
module instr_sequencer
    import seq_pkg::*;
#(
    parameter int PC_W = 8,
    parameter int NREG = 8
) (
    input wire logic           clk,
    input wire logic           rst,
    instr_sequencer_if.master  bus
);
    localparam logic [PC_W-1:0] c_pc_one = PC_W'(1);

    state_t          r_state, w_next;
    logic [PC_W-1:0] r_pc, w_pc_next;
    logic [15:0]     r_ir, r_res;
    logic [1:0]      r_flgreg, r_flg_cap;
    logic            r_imem_req, r_alu_en, r_halted;
    logic [2:0]      r_alu_op;
    logic [15:0]     r_alu_d1, r_alu_d2;
    logic [15:0]     w_rdata1, w_rdata2, w_wdata;
    logic            w_we, w_fetch_done;
    logic [3:0]      w_opc;
    logic [2:0]      w_rd, w_rs1, w_rs2;
    logic [PC_W-1:0] w_target;

    assign w_opc    = r_ir[c_opc_lsb +: 4];
    assign w_rd     = r_ir[c_rd_lsb  +: 3];
    assign w_rs1    = r_ir[c_rs1_lsb +: 3];
    assign w_rs2    = r_ir[c_rs2_lsb +: 3];
    assign w_target = r_ir[PC_W-1:0];
    // ack only counts once the registered request is actually visible
    assign w_fetch_done = (r_state == ST_FETCH) && r_imem_req && bus.imem_ack;

    reg_file #(.NREG(NREG)) u_rf (
        .clk      (clk),
        .rst      (rst),
        .i_we     (w_we),
        .i_waddr  (w_rd),
        .i_wdata  (w_wdata),
        .i_raddr1 (w_rs1),
        .i_raddr2 (w_rs2),
        .o_rdata1 (w_rdata1),
        .o_rdata2 (w_rdata2)
    );

    always_comb begin
        w_next    = r_state;
        w_we      = 1'b0;
        w_wdata   = r_res;
        w_pc_next = r_pc;
        case (r_state)
            ST_FETCH:  if (w_fetch_done) w_next = ST_DECODE;
            ST_DECODE: w_next = ST_EXEC;
            ST_EXEC:   w_next = ST_WB;
            ST_WB: begin
                w_next    = (w_opc == c_opc_halt) ? ST_HALT : ST_FETCH;
                w_pc_next = r_pc + c_pc_one;
                case (w_opc)
                    c_opc_add, c_opc_sub, c_opc_and, c_opc_or, c_opc_not: w_we = 1'b1;
                    c_opc_ldi: begin
                        w_we    = 1'b1;
                        w_wdata = {{7{r_ir[8]}}, r_ir[8:0]};
                    end
                    c_opc_jmp:  w_pc_next = w_target;
                    c_opc_bz:   if (r_flgreg[c_flg_zero]) w_pc_next = w_target;
                    c_opc_bn:   if (r_flgreg[c_flg_neg])  w_pc_next = w_target;
                    c_opc_halt: w_pc_next = r_pc;
                    default:    ;
                endcase
            end
            ST_HALT:   w_next = ST_HALT;
            default:   w_next = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_FETCH;
            r_pc       <= '0;
            r_ir       <= '0;
            r_res      <= '0;
            r_flgreg   <= '0;
            r_flg_cap  <= '0;
            r_imem_req <= 1'b0;
            r_alu_en   <= 1'b0;
            r_alu_op   <= c_alu_add;
            r_alu_d1   <= '0;
            r_alu_d2   <= '0;
            r_halted   <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_pc       <= w_pc_next;
            r_imem_req <= (w_next == ST_FETCH);
            if (w_fetch_done) r_ir <= bus.imem_data;
            // ALU drive is live only for the EXEC cycle and zero otherwise
            if (r_state == ST_DECODE && uses_alu(w_opc)) begin
                r_alu_en <= 1'b1;
                r_alu_op <= alu_op_of(w_opc);
                r_alu_d1 <= w_rdata1;
                r_alu_d2 <= w_rdata2;
            end else begin
                r_alu_en <= 1'b0;
                r_alu_op <= c_alu_add;
                r_alu_d1 <= '0;
                r_alu_d2 <= '0;
            end
            if (r_state == ST_EXEC) begin
                r_res     <= bus.alureg;
                r_flg_cap <= bus.flg;
            end
            if (r_state == ST_WB && uses_alu(w_opc)) r_flgreg <= r_flg_cap;
            if (w_next == ST_HALT) r_halted <= 1'b1;
        end
    end

    assign bus.imem_req  = r_imem_req;
    assign bus.imem_addr = r_pc;
    assign bus.alu_en    = r_alu_en;
    assign bus.alu_flgon = r_alu_en;
    assign bus.alu_op    = r_alu_op;
    assign bus.alu_d1    = r_alu_d1;
    assign bus.alu_d2    = r_alu_d2;
    assign bus.halted    = r_halted;
endmodule
`default_nettype wire
